keypad_scan_debounce: RTL and testbench
=======================================

# keypad_scan_debounce

Scans the 3x3 matrix keypad and delivers one clean, debounced key code per physical press to the digit-entry, length-check and validity-check logic. It drives the row lines and samples the column lines. It outputs a held key code `button` and a level `bstate` that is high while a key is held. The falling edge of `bstate` marks the end of a press, which downstream logic acts on. The block sits directly between the keypad pins and the digit-entry stage.

## Interface
Parameters:
- `SCAN_DIV`, default 12000: hwclk cycles per row slot (1 ms at 12 MHz).
- `DEBOUNCE_FRAMES`, default 16: number of consecutive identical scan frames required to accept a press or a release.

Ports:
- `hwclk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `keypad_r1`, `keypad_r2`, `keypad_r3`, out, 1 each: row drives, active-low, one-hot-low.
- `keypad_c1`, `keypad_c2`, `keypad_c3`, in, 1 each: column senses, externally pulled up. Low means pressed.
- `button`, out, 4: last accepted key code, 1..9.
- `bstate`, out, 1: high while the accepted key is held.
- `key_pulse`, out, 1: one-cycle strobe when a press is accepted.

## Operation
- Column inputs pass through a 2-FF synchronizer before any use.
- Row scanning:
  - A slot counter runs 0..SCAN_DIV-1. Rows are driven in the order r1, r2, r3, then wrap.
  - Exactly one row is low at any time. Rows are never all high after reset.
- Column sampling:
  - Columns are sampled once per slot, at count SCAN_DIV-1 (settled value).
  - The sample is taken before the row advances.
- Key codes:
  - Row 1 gives 1/2/3 for c1/c2/c3. Row 2 gives 4/5/6. Row 3 gives 7/8/9.
- Frame result: after the r3 sample, the three samples form one frame result.
  - NONE: no column was low in any row.
  - KEY(n): exactly one (row, column) was low.
  - MULTI: more than one was low. MULTI counts as neither a press nor a release. It resets the debounce counter and holds the current state.
- Debounce FSM, states RELEASED and HELD. The frame counter is 5 bits and saturates at DEBOUNCE_FRAMES.
  - RELEASED:
    - Track a candidate code.
    - KEY(n) equal to the candidate increments the counter. A different KEY(n) loads it as the new candidate and sets the counter to 1.
    - NONE or MULTI clears the counter.
    - When the counter reaches DEBOUNCE_FRAMES: load `button` = n, set `bstate` = 1, pulse `key_pulse` for one cycle, go to HELD, clear the counter.
  - HELD:
    - NONE increments the counter. Any other result clears it.
    - When the counter reaches DEBOUNCE_FRAMES: set `bstate` = 0, go to RELEASED. `button` keeps its value.
    - A different key appearing while HELD is not accepted until release is accepted.
- Reset values: rows = (r1=0, r2=1, r3=1), slot count 0, `button` = 0, `bstate` = 0, `key_pulse` = 0, state RELEASED, candidate 0, counter 0.
- Reset asserted mid-press forces the reset values on the next edge. Any frame in progress is discarded.

## Timing
- One frame = 3·SCAN_DIV cycles. The frame result is valid on the cycle after the r3 sample.
- Press latency, from a stable press to `bstate` rising: between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames, plus 2 cycles for the synchronizer.
- Release latency has the same bound.
- `key_pulse` and the rise of `bstate` occur in the same cycle. `button` is updated in that same cycle.
- `button` is stable for the whole time `bstate` is high and through its falling edge. Downstream can therefore latch `button` on negedge `bstate`.
- Minimum `bstate` high time and low time: DEBOUNCE_FRAMES frames each.

## Structure
- Shared package/header holds:
  - key code constants KEY_1..KEY_9;
  - frame-result encoding NONE=2'd0, KEY=2'd1, MULTI=2'd2;
  - FSM state encoding.
- One sub-module, `matrix_scanner`: row drive, slot counter, synchronizer and frame assembly. It outputs `frame_valid`, `frame_kind` and `frame_code`.
- The debounce FSM lives in the top of this block.

## Test plan
All scenarios use the bench values SCAN_DIV=4 and DEBOUNCE_FRAMES=3.
- Reset, then idle columns held high:
  - rows cycle 011→101→110 every 4 cycles;
  - `bstate` stays 0, `button` stays 0, `key_pulse` never fires.
- Model key 5 (c2 low while r2 low) for 20 frames, then release:
  - one `key_pulse` occurs, with `button` = 5;
  - `bstate` rises about 3 frames after press onset and falls about 3 frames after release.
- Bounce: toggle key 7 on/off every frame for 10 frames, then hold for 5 frames:
  - no acceptance during the toggling;
  - exactly one press accepted, with `button` = 7.
- Keys 1 and 9 held together for 10 frames:
  - MULTI every frame;
  - no `key_pulse`, `bstate` stays 0.
- Hold key 3 until accepted, then switch directly to key 4 with no release:
  - `bstate` stays 1 and `button` stays 3;
  - after a real release and a press of 4, `button` = 4.
- Assert `rst` for 1 cycle while HELD on key 2:
  - next cycle `bstate` = 0, `button` = 0 and rows = 011;
  - with key 2 still held, a fresh acceptance occurs after 3 frames.

Source files
------------

// File: rtl/keypad_scan_debounce_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce_pkg
// Shared definitions for the 3x3 keypad scanner and its debounce FSM:
//   - key code constants KEY_1..KEY_9 (KEY_NONE = 0 means "no key")
//   - frame-result encoding produced once per full scan of the three rows
//   - debounce FSM state encoding
//   - small helpers for key-code lookup, row-drive pattern and hit counting
// -----------------------------------------------------------------------------
package keypad_scan_debounce_pkg;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;

    // Width of the debounce frame counter.
    localparam int FRAME_CNT_W = 5;

    typedef enum logic [1:0] {
        FRAME_NONE  = 2'd0,
        FRAME_KEY   = 2'd1,
        FRAME_MULTI = 2'd2
    } frame_kind_t;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } db_state_t;

    // Key code for a (row, column) pair, rows/columns indexed from 0.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] base;
        case (row)
            2'd0:    base = KEY_1;
            2'd1:    base = KEY_4;
            2'd2:    base = KEY_7;
            default: base = KEY_NONE;
        endcase
        if ((base == KEY_NONE) || (col > 2'd2)) begin
            return KEY_NONE;
        end else begin
            return base + {2'b00, col};
        end
    endfunction

    // Active-low row drive pattern {r3, r2, r1} for a row index.
    // Any out-of-range index falls back to row 1 so exactly one row is low.
    function automatic logic [2:0] row_drive(input logic [1:0] row);
        case (row)
            2'd0:    return 3'b110;
            2'd1:    return 3'b101;
            2'd2:    return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    // Number of set bits in a 3-bit vector.
    function automatic logic [1:0] ones_count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_scanner.sv
// -----------------------------------------------------------------------------
// matrix_scanner
// Drives the keypad rows one at a time (active low), synchronizes the column
// senses and assembles one frame result after every full r1/r2/r3 scan.
//
// Ports:
//   hwclk        in   clock, rising edge
//   rst          in   synchronous active-high reset
//   col_n[2:0]   in   raw column senses {c3,c2,c1}, low = pressed
//   row_n[2:0]   out  row drives {r3,r2,r1}, exactly one low (registered)
//   frame_valid  out  one-cycle strobe, high the cycle after the r3 sample
//   frame_kind   out  NONE / KEY / MULTI for the completed frame
//   frame_code   out  key code when frame_kind is KEY, else 0
// -----------------------------------------------------------------------------
module matrix_scanner
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SCAN_DIV = 12000
)
(
    input  logic       hwclk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [2:0] row_n,
    output logic       frame_valid,
    output logic [1:0] frame_kind,
    output logic [3:0] frame_code
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [2:0]        col_meta_r;
    logic [2:0]        col_sync_r;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [1:0]        row_idx_r;
    logic [1:0]        row_idx_nxt_s;
    logic [2:0]        row_n_r;
    logic [1:0]        hit_cnt_r;
    logic [3:0]        hit_code_r;
    logic              frame_valid_r;
    frame_kind_t       frame_kind_r;
    logic [3:0]        frame_code_r;

    logic              slot_end_s;
    logic              last_row_s;
    logic [2:0]        hits_s;
    logic [1:0]        row_hits_s;
    logic [1:0]        hit_col_s;
    logic [2:0]        hit_sum_s;
    logic [1:0]        hit_total_s;
    logic [3:0]        code_acc_s;
    frame_kind_t       kind_s;

    assign slot_end_s = (slot_cnt_r == SLOT_LAST);
    assign last_row_s = (row_idx_r >= 2'd2);
    assign hits_s     = ~col_sync_r;
    assign row_hits_s = ones_count3(hits_s);

    // Two-flop synchronizer on the column senses (idle level is high)
    always_ff @(posedge hwclk) begin
        if (rst) begin
            col_meta_r <= 3'b111;
            col_sync_r <= 3'b111;
        end else begin
            col_meta_r <= col_n;
            col_sync_r <= col_meta_r;
        end
    end

    // Next row index: advance only at the end of a slot, after the sample
    always_comb begin
        row_idx_nxt_s = row_idx_r;
        if (slot_end_s) begin
            if (last_row_s) begin
                row_idx_nxt_s = 2'd0;
            end else begin
                row_idx_nxt_s = row_idx_r + 2'd1;
            end
        end else begin
            row_idx_nxt_s = row_idx_r;
        end
    end

    // Slot counter and row drive registers
    always_ff @(posedge hwclk) begin
        if (rst) begin
            slot_cnt_r <= '0;
            row_idx_r  <= 2'd0;
            row_n_r    <= 3'b110;
        end else begin
            if (slot_end_s) begin
                slot_cnt_r <= '0;
            end else begin
                slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
            end
            row_idx_r <= row_idx_nxt_s;
            // Drive pattern is rebuilt from the index so a corrupted pattern
            // cannot persist across a row change.
            row_n_r   <= row_drive(row_idx_nxt_s);
        end
    end

    // Column of the pressed key when exactly one column is low this slot
    always_comb begin
        hit_col_s = 2'd0;
        if (hits_s[0]) begin
            hit_col_s = 2'd0;
        end else if (hits_s[1]) begin
            hit_col_s = 2'd1;
        end else if (hits_s[2]) begin
            hit_col_s = 2'd2;
        end else begin
            hit_col_s = 2'd0;
        end
    end

    // Running hit count (saturating at 2 = multi) and candidate code
    always_comb begin
        hit_sum_s   = {1'b0, hit_cnt_r} + {1'b0, row_hits_s};
        hit_total_s = 2'd0;
        code_acc_s  = hit_code_r;
        kind_s      = FRAME_NONE;
        if (hit_sum_s >= 3'd2) begin
            hit_total_s = 2'd2;
        end else begin
            hit_total_s = hit_sum_s[1:0];
        end
        if (row_hits_s == 2'd1) begin
            code_acc_s = key_code(row_idx_r, hit_col_s);
        end else begin
            code_acc_s = hit_code_r;
        end
        case (hit_total_s)
            2'd0:    kind_s = FRAME_NONE;
            2'd1:    kind_s = FRAME_KEY;
            default: kind_s = FRAME_MULTI;
        endcase
    end

    // Per-slot sample accumulation and frame result publication
    always_ff @(posedge hwclk) begin
        if (rst) begin
            hit_cnt_r     <= 2'd0;
            hit_code_r    <= KEY_NONE;
            frame_valid_r <= 1'b0;
            frame_kind_r  <= FRAME_NONE;
            frame_code_r  <= KEY_NONE;
        end else begin
            frame_valid_r <= 1'b0;
            if (slot_end_s) begin
                if (last_row_s) begin
                    frame_valid_r <= 1'b1;
                    frame_kind_r  <= kind_s;
                    frame_code_r  <= (kind_s == FRAME_KEY) ? code_acc_s : KEY_NONE;
                    hit_cnt_r     <= 2'd0;
                    hit_code_r    <= KEY_NONE;
                end else begin
                    hit_cnt_r     <= hit_total_s;
                    hit_code_r    <= code_acc_s;
                end
            end else begin
                hit_cnt_r  <= hit_cnt_r;
                hit_code_r <= hit_code_r;
            end
        end
    end

    assign row_n       = row_n_r;
    assign frame_valid = frame_valid_r;
    assign frame_kind  = frame_kind_r;
    assign frame_code  = frame_code_r;

endmodule

// File: rtl/keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce
// Scans a 3x3 matrix keypad and turns raw frame results into one clean,
// debounced key event per physical press.
//
// Ports:
//   hwclk                      in   clock, rising edge
//   rst                        in   synchronous active-high reset
//   keypad_r1/r2/r3            out  row drives, active low, one low at a time
//   keypad_c1/c2/c3            in   column senses, pulled up, low = pressed
//   button[3:0]                out  last accepted key code (1..9), 0 after reset
//   bstate                     out  high while the accepted key is held
//   key_pulse                  out  one-cycle strobe when a press is accepted
//
// button only changes on acceptance, so it is stable while bstate is high and
// through bstate's falling edge.
// -----------------------------------------------------------------------------
module keypad_scan_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_FRAMES = 16
)
(
    input  logic       hwclk,
    input  logic       rst,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_pulse
);

    localparam logic [FRAME_CNT_W-1:0] DB_TARGET = FRAME_CNT_W'(DEBOUNCE_FRAMES);

    logic [2:0]             row_n_s;
    logic                   frame_valid_s;
    logic [1:0]             frame_kind_s;
    logic [3:0]             frame_code_s;

    db_state_t              state_r;
    db_state_t              state_nxt_s;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt_s;
    logic [FRAME_CNT_W-1:0] frame_cnt_inc_s;
    logic [FRAME_CNT_W-1:0] frame_cnt_try_s;
    logic [3:0]             cand_r;
    logic [3:0]             cand_nxt_s;
    logic                   accept_s;
    logic [3:0]             button_r;
    logic [3:0]             button_nxt_s;
    logic                   bstate_r;
    logic                   bstate_nxt_s;
    logic                   key_pulse_r;
    logic                   key_pulse_nxt_s;

    matrix_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .hwclk       (hwclk),
        .rst         (rst),
        .col_n       ({keypad_c3, keypad_c2, keypad_c1}),
        .row_n       (row_n_s),
        .frame_valid (frame_valid_s),
        .frame_kind  (frame_kind_s),
        .frame_code  (frame_code_s)
    );

    assign keypad_r1 = row_n_s[0];
    assign keypad_r2 = row_n_s[1];
    assign keypad_r3 = row_n_s[2];

    // Saturating increment of the debounce frame counter
    assign frame_cnt_inc_s = (frame_cnt_r >= DB_TARGET) ? DB_TARGET
                                                        : frame_cnt_r + FRAME_CNT_W'(1);

    // Debounce FSM state and output registers
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r     <= ST_RELEASED;
            frame_cnt_r <= '0;
            cand_r      <= KEY_NONE;
            button_r    <= KEY_NONE;
            bstate_r    <= 1'b0;
            key_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            cand_r      <= cand_nxt_s;
            button_r    <= button_nxt_s;
            bstate_r    <= bstate_nxt_s;
            key_pulse_r <= key_pulse_nxt_s;
        end
    end

    // Debounce FSM next-state: counts identical frames towards press/release
    always_comb begin
        state_nxt_s     = state_r;
        frame_cnt_nxt_s = frame_cnt_r;
        frame_cnt_try_s = frame_cnt_r;
        cand_nxt_s      = cand_r;
        accept_s        = 1'b0;
        if (frame_valid_s) begin
            case (state_r)
                ST_RELEASED: begin
                    if (frame_kind_s == FRAME_KEY) begin
                        if (frame_code_s == cand_r) begin
                            frame_cnt_try_s = frame_cnt_inc_s;
                        end else begin
                            // A different key restarts the count on the new candidate.
                            cand_nxt_s      = frame_code_s;
                            frame_cnt_try_s = FRAME_CNT_W'(1);
                        end
                        if (frame_cnt_try_s >= DB_TARGET) begin
                            state_nxt_s     = ST_HELD;
                            frame_cnt_nxt_s = '0;
                            accept_s        = 1'b1;
                        end else begin
                            frame_cnt_nxt_s = frame_cnt_try_s;
                        end
                    end else begin
                        // NONE and MULTI both break a press streak.
                        frame_cnt_nxt_s = '0;
                    end
                end
                ST_HELD: begin
                    if (frame_kind_s == FRAME_NONE) begin
                        if (frame_cnt_inc_s >= DB_TARGET) begin
                            state_nxt_s     = ST_RELEASED;
                            frame_cnt_nxt_s = '0;
                        end else begin
                            frame_cnt_nxt_s = frame_cnt_inc_s;
                        end
                    end else begin
                        // Any key (same, different or several) means not released.
                        frame_cnt_nxt_s = '0;
                    end
                end
                default: begin
                    state_nxt_s     = ST_RELEASED;
                    frame_cnt_nxt_s = '0;
                end
            endcase
        end else begin
            state_nxt_s     = state_r;
            frame_cnt_nxt_s = frame_cnt_r;
        end
    end

    // Debounce FSM outputs: code latch, held level and acceptance strobe
    always_comb begin
        button_nxt_s    = button_r;
        key_pulse_nxt_s = 1'b0;
        bstate_nxt_s    = (state_nxt_s == ST_HELD);
        if (accept_s) begin
            button_nxt_s    = frame_code_s;
            key_pulse_nxt_s = 1'b1;
        end else begin
            button_nxt_s    = button_r;
            key_pulse_nxt_s = 1'b0;
        end
    end

    assign button    = button_r;
    assign bstate    = bstate_r;
    assign key_pulse = key_pulse_r;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

    logic       hwclk;
    logic       rst;
    logic       keypad_r1;
    logic       keypad_r2;
    logic       keypad_r3;
    logic       keypad_c1;
    logic       keypad_c2;
    logic       keypad_c3;
    logic [3:0] button;
    logic       bstate;
    logic       key_pulse;

    // keys[k-1] set means key k is physically pressed
    logic [8:0] keys;

    int checks;
    int errors;
    int pulse_cnt;
    int pulse_btn;
    int multi_cnt;
    int multi_base;

    keypad_scan_debounce #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .hwclk     (hwclk),
        .rst       (rst),
        .keypad_r1 (keypad_r1),
        .keypad_r2 (keypad_r2),
        .keypad_r3 (keypad_r3),
        .keypad_c1 (keypad_c1),
        .keypad_c2 (keypad_c2),
        .keypad_c3 (keypad_c3),
        .button    (button),
        .bstate    (bstate),
        .key_pulse (key_pulse)
    );

    // Passive keypad matrix: a column is pulled low by any pressed key on a low row
    assign keypad_c1 = ~((~keypad_r1 & keys[0]) | (~keypad_r2 & keys[3]) | (~keypad_r3 & keys[6]));
    assign keypad_c2 = ~((~keypad_r1 & keys[1]) | (~keypad_r2 & keys[4]) | (~keypad_r3 & keys[7]));
    assign keypad_c3 = ~((~keypad_r1 & keys[2]) | (~keypad_r2 & keys[5]) | (~keypad_r3 & keys[8]));

    initial begin
        hwclk = 1'b0;
        forever #5 hwclk = ~hwclk;
    end

    // Event monitors sampled on the falling edge
    initial begin
        pulse_cnt = 0;
        pulse_btn = 0;
        multi_cnt = 0;
        forever begin
            @(negedge hwclk);
            if (key_pulse === 1'b1) begin
                pulse_cnt = pulse_cnt + 1;
                pulse_btn = int'(button);
            end
            if ((dut.u_scanner.frame_valid === 1'b1) && (dut.u_scanner.frame_kind === 2'd2)) begin
                multi_cnt = multi_cnt + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] rows3();
        return {29'd0, keypad_r1, keypad_r2, keypad_r3};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        keys   = 9'h000;

        // Reset state
        step(3);
        chk("rst_rows",   rows3(), 32'h3);
        chk("rst_bstate", 32'(bstate), 32'd0);
        chk("rst_button", 32'(button), 32'd0);
        chk("rst_pulse",  32'(key_pulse), 32'd0);
        rst = 1'b0;

        // Idle: rows rotate 011 -> 101 -> 110 every 4 cycles
        step(3);
        chk("idle_rows_r1a", rows3(), 32'h3);
        step(1);
        chk("idle_rows_r2",  rows3(), 32'h5);
        step(4);
        chk("idle_rows_r3",  rows3(), 32'h6);
        step(4);
        chk("idle_rows_r1b", rows3(), 32'h3);
        step(36);
        chk("idle_bstate", 32'(bstate), 32'd0);
        chk("idle_button", 32'(button), 32'd0);
        chk("idle_pulses", pulse_cnt, 32'd0);
        chk("idle_align",  rows3(), 32'h3);

        // Key 5 held 20 frames, then released
        keys = 9'h010;
        step(36);
        chk("k5_before",   32'(bstate), 32'd0);
        step(1);
        chk("k5_bstate",   32'(bstate), 32'd1);
        chk("k5_pulse",    32'(key_pulse), 32'd1);
        chk("k5_button",   32'(button), 32'd5);
        step(1);
        chk("k5_pulse_end", 32'(key_pulse), 32'd0);
        step(202);
        keys = 9'h000;
        step(36);
        chk("k5_still_held", 32'(bstate), 32'd1);
        step(1);
        chk("k5_released", 32'(bstate), 32'd0);
        chk("k5_btn_kept", 32'(button), 32'd5);
        step(11);
        chk("k5_pulses",   pulse_cnt, 32'd1);
        chk("k5_align",    rows3(), 32'h3);

        // Key 7 bouncing every frame, then held
        for (int i = 0; i < 10; i++) begin
            keys = ((i % 2) == 0) ? 9'h040 : 9'h000;
            step(12);
        end
        chk("bounce_pulses", pulse_cnt, 32'd1);
        chk("bounce_bstate", 32'(bstate), 32'd0);
        keys = 9'h040;
        step(60);
        chk("k7_pulses", pulse_cnt, 32'd2);
        chk("k7_pbtn",   pulse_btn, 32'd7);
        chk("k7_bstate", 32'(bstate), 32'd1);
        chk("k7_button", 32'(button), 32'd7);
        keys = 9'h000;
        step(48);
        chk("k7_released", 32'(bstate), 32'd0);

        // Keys 1 and 9 together: MULTI every frame, never accepted
        multi_base = multi_cnt;
        keys = 9'h101;
        step(120);
        chk("multi_bstate", 32'(bstate), 32'd0);
        keys = 9'h000;
        step(12);
        chk("multi_frames", multi_cnt - multi_base, 32'd10);
        chk("multi_pulses", pulse_cnt, 32'd2);

        // Key 3 accepted, slide to key 4 without release
        keys = 9'h004;
        step(37);
        chk("k3_bstate", 32'(bstate), 32'd1);
        chk("k3_button", 32'(button), 32'd3);
        chk("k3_pulse",  32'(key_pulse), 32'd1);
        step(11);
        keys = 9'h008;
        step(60);
        chk("slide_bstate", 32'(bstate), 32'd1);
        chk("slide_button", 32'(button), 32'd3);
        chk("slide_pulses", pulse_cnt, 32'd3);
        keys = 9'h000;
        step(48);
        chk("k3_released", 32'(bstate), 32'd0);
        chk("k3_btn_kept", 32'(button), 32'd3);
        keys = 9'h008;
        step(37);
        chk("k4_bstate", 32'(bstate), 32'd1);
        chk("k4_button", 32'(button), 32'd4);
        chk("k4_pulse",  32'(key_pulse), 32'd1);
        step(11);
        keys = 9'h000;
        step(48);
        chk("k4_released", 32'(bstate), 32'd0);
        chk("k4_pulses", pulse_cnt, 32'd4);

        // Reset while held on key 2, key kept pressed afterwards
        keys = 9'h002;
        step(48);
        chk("k2_bstate", 32'(bstate), 32'd1);
        chk("k2_button", 32'(button), 32'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_bstate", 32'(bstate), 32'd0);
        chk("mid_rst_button", 32'(button), 32'd0);
        chk("mid_rst_rows",   rows3(), 32'h3);
        chk("mid_rst_pulse",  32'(key_pulse), 32'd0);
        step(36);
        chk("k2_re_before", 32'(bstate), 32'd0);
        step(1);
        chk("k2_re_bstate", 32'(bstate), 32'd1);
        chk("k2_re_button", 32'(button), 32'd2);
        chk("k2_re_pulse",  32'(key_pulse), 32'd1);
        step(11);
        keys = 9'h000;
        step(48);
        chk("k2_released",  32'(bstate), 32'd0);
        chk("total_pulses", pulse_cnt, 32'd6);
        chk("last_pbtn",    pulse_btn, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
